// File: rtl/ocimem_dbg_pkg.sv
// Shared definitions for the OCI debug memory access engine: engine states,
// jdo payload field positions and timeout sizing.
package ocimem_dbg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_REQ  = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_WR_REQ  = 2'd3
    } ocimem_state_e;

    // jdo payload layout
    localparam int JDO_W  = 38;
    localparam int RD_BIT = 37;  // ocimem_a: read request
    localparam int AI_BIT = 36;  // ocimem_a: auto-increment enable
    localparam int WD_MSB = 35;  // ocimem_b: write data
    localparam int WD_LSB = 4;
    localparam int BE_MSB = 3;   // ocimem_b: byteenable [3:0]

    localparam int DEF_TIMEOUT = 255;
    localparam int MIN_CNT_W   = 8;

    // Counter wide enough to hold TIMEOUT, never narrower than 8 bits.
    function automatic int cnt_width(input int limit);
        int w;
        w = $clog2(limit + 1);
        return (w < MIN_CNT_W) ? MIN_CNT_W : w;
    endfunction

endpackage

// File: rtl/ocimem_dbg_timeout_ctr.sv
// Bus-cycle watchdog: cleared while the engine is idle, counts every busy
// cycle, and flags expiry from the LIMIT-th busy cycle onward.
module ocimem_dbg_timeout_ctr
    import ocimem_dbg_pkg::*;
#(
    parameter int LIMIT = DEF_TIMEOUT,
    parameter int CNT_W = MIN_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt;

    // Busy-cycle counter; load restarts it from zero.
    always_ff @(posedge clk) begin
        if (reset || load)
            cnt <= '0;
        else if (en)
            cnt <= cnt + CNT_W'(1);
    end

    // >= rather than == so expiry stays asserted if a read is accepted on
    // the last allowed cycle and then waits in RD_WAIT.
    assign expire = en && (cnt >= LAST);

endmodule

// File: rtl/ocimem_debug_access.sv
// Sysclk-side OCI debug memory engine: turns debug-slave strobes plus the
// jdo payload into single-word Avalon-MM reads/writes and reports the
// result back as MonDReg / monitor_ready / monitor_error.
module ocimem_debug_access
    import ocimem_dbg_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    output logic [3:0]        avm_byteenable,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_readdatavalid
);

    localparam int CNT_W = cnt_width(TIMEOUT);

    ocimem_state_e     state, state_nxt;
    logic [ADDR_W-1:0] addr;
    logic              autoinc;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;
    logic              expire;

    logic any_strobe;
    logic rd_accept;
    logic rd_done;
    logic wr_done;
    logic xfer_done;
    logic timeout_hit;

    assign any_strobe  = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    assign rd_accept   = (state == ST_RD_REQ) && !avm_waitrequest;
    // Zero-latency readdatavalid on the accept cycle completes the read directly.
    assign rd_done     = (rd_accept && avm_readdatavalid) ||
                         ((state == ST_RD_WAIT) && avm_readdatavalid);
    assign wr_done     = (state == ST_WR_REQ) && !avm_waitrequest;
    assign xfer_done   = rd_done || wr_done;
    // Progress on the bus wins over an expiry in the same cycle.
    assign timeout_hit = expire && !rd_accept && !rd_done && !wr_done;

    ocimem_dbg_timeout_ctr #(
        .LIMIT (TIMEOUT),
        .CNT_W (CNT_W)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .load   (state == ST_IDLE),
        .en     (state != ST_IDLE),
        .expire (expire)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state decode; strobe priority in IDLE is a > b > no_action.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (take_action_ocimem_a)
                    state_nxt = jdo[RD_BIT] ? ST_RD_REQ : ST_IDLE;
                else if (take_action_ocimem_b)
                    state_nxt = ST_WR_REQ;
                else if (take_no_action_ocimem_a)
                    state_nxt = ST_RD_REQ;
            end
            ST_RD_REQ: begin
                if (rd_done)
                    state_nxt = ST_IDLE;
                else if (rd_accept)
                    state_nxt = ST_RD_WAIT;
                else if (timeout_hit)
                    state_nxt = ST_IDLE;
            end
            ST_RD_WAIT: begin
                if (rd_done || timeout_hit)
                    state_nxt = ST_IDLE;
            end
            ST_WR_REQ: begin
                if (wr_done || timeout_hit)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Bus outputs decoded from state so reset/timeout drop requests on the edge.
    always_comb begin
        avm_read       = 1'b0;
        avm_write      = 1'b0;
        avm_byteenable = 4'h0;
        avm_writedata  = 32'h0;
        case (state)
            ST_RD_REQ: begin
                avm_read       = 1'b1;
                avm_byteenable = 4'hF;
            end
            ST_WR_REQ: begin
                avm_write      = 1'b1;
                avm_byteenable = be_q;
                avm_writedata  = wdata_q;
            end
            default: ;
        endcase
    end

    assign avm_address = addr;

    // Command latching, read capture, auto-increment and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr          <= '0;
            autoinc       <= 1'b0;
            wdata_q       <= 32'h0;
            be_q          <= 4'h0;
            MonDReg       <= 32'h0;
            monitor_ready <= 1'b1;
            monitor_error <= 1'b0;
        end else begin
            if (state == ST_IDLE) begin
                if (take_action_ocimem_a) begin
                    addr          <= jdo[ADDR_W-1:0];
                    autoinc       <= jdo[AI_BIT];
                    monitor_error <= 1'b0;
                    monitor_ready <= 1'b0;
                end else if (take_action_ocimem_b) begin
                    wdata_q       <= jdo[WD_MSB:WD_LSB];
                    be_q          <= jdo[BE_MSB:0];
                    monitor_ready <= 1'b0;
                end else if (take_no_action_ocimem_a) begin
                    monitor_ready <= 1'b0;
                end else begin
                    // Address-only ocimem_a drops ready for exactly one cycle.
                    monitor_ready <= 1'b1;
                end
            end else begin
                // A command arriving mid-transaction is dropped and flagged.
                if (any_strobe)
                    monitor_error <= 1'b1;
                if (rd_done)
                    MonDReg <= avm_readdata;
                if (xfer_done) begin
                    monitor_ready <= 1'b1;
                    if (autoinc)
                        addr <= addr + ADDR_W'(1);
                end else if (timeout_hit) begin
                    monitor_ready <= 1'b1;
                    monitor_error <= 1'b1;
                end
            end
        end
    end

endmodule
